// File: rtl/step_fsm_gen.sv
// Up/down state stepper with optional top->0 wrap, a synchronous load and a
// saturating wrap-event counter. Only the state register drives at_top/at_bottom.
module step_fsm_gen #(
  parameter int unsigned NUM_STATES = 7,
  parameter int unsigned SAT_MODE   = 0,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned SW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             step_up,
  input  logic             load,
  input  logic [SW-1:0]    load_val,
  input  logic             clr_cnt,
  output logic [SW-1:0]    state,
  output logic             at_top,
  output logic             at_bottom,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             load_err
);

  localparam logic [SW-1:0] TOP = SW'(NUM_STATES - 1);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_LOAD_OOR,
    ACT_UP,
    ACT_DOWN,
    ACT_RECOVER
  } act_e;

  act_e             act;
  logic [SW-1:0]    state_q, state_d;
  logic             wrap_pulse_q, wrap_pulse_d;
  logic [CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic             load_err_q, load_err_d;

  // One action per cycle; an illegal encoding overrides everything and returns to 0.
  always_comb begin
    act = ACT_HOLD;
    if (32'(state_q) >= NUM_STATES) begin
      act = ACT_RECOVER;
    end else if (load) begin
      act = (32'(load_val) < NUM_STATES) ? ACT_LOAD : ACT_LOAD_OOR;
    end else if (en) begin
      act = step_up ? ACT_UP : ACT_DOWN;
    end
  end

  always_comb begin
    state_d      = state_q;
    wrap_pulse_d = 1'b0;
    load_err_d   = 1'b0;
    case (act)
      ACT_LOAD:     state_d = load_val;
      ACT_LOAD_OOR: begin
        state_d    = TOP;
        load_err_d = 1'b1;
      end
      ACT_UP: begin
        if (state_q != TOP) begin
          state_d = state_q + SW'(1);
        end else if (SAT_MODE == 0) begin
          state_d      = '0;
          wrap_pulse_d = 1'b1;
        end
      end
      ACT_DOWN: begin
        if (state_q != '0) state_d = state_q - SW'(1);
      end
      ACT_RECOVER:  state_d = '0;
      default:      ;
    endcase
  end

  // Clear wins over a coincident wrap; the pulse itself is unaffected.
  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (clr_cnt) begin
      wrap_cnt_d = '0;
    end else if (wrap_pulse_d && (wrap_cnt_q != '1)) begin
      wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      load_err_q   <= load_err_d;
    end
  end

  assign state      = state_q;
  assign at_top     = (state_q == TOP);
  assign at_bottom  = (state_q == '0);
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_step_fsm_gen.sv
// Bench for step_fsm_gen: three instances (default, saturating, 2-bit counter)
// share stimulus and are checked against an arithmetic reference model.
module tb_step_fsm_gen;

  localparam int NS = 7;

  logic       clk = 1'b0;
  logic       reset, en, step_up, load, clr_cnt;
  logic [2:0] load_val;

  logic [2:0] st0, st1, st2;
  logic       top0, top1, top2, bot0, bot1, bot2;
  logic       wp0, wp1, wp2, le0, le1, le2;
  logic [7:0] wc0, wc1;
  logic [1:0] wc2;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       top;
    logic       bot;
    logic       wp;
    logic [7:0] wc;
    logic       le;
  } obs_t;

  int m_st[3];
  int m_wc[3];
  bit m_wp[3];
  bit m_le[3];
  int m_sat[3]  = '{0, 1, 0};
  int m_cmax[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  step_fsm_gen #(.NUM_STATES(7), .SAT_MODE(0), .CNT_W(8)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .step_up(step_up), .load(load),
    .load_val(load_val), .clr_cnt(clr_cnt), .state(st0), .at_top(top0),
    .at_bottom(bot0), .wrap_pulse(wp0), .wrap_cnt(wc0), .load_err(le0));

  step_fsm_gen #(.NUM_STATES(7), .SAT_MODE(1), .CNT_W(8)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .step_up(step_up), .load(load),
    .load_val(load_val), .clr_cnt(clr_cnt), .state(st1), .at_top(top1),
    .at_bottom(bot1), .wrap_pulse(wp1), .wrap_cnt(wc1), .load_err(le1));

  step_fsm_gen #(.NUM_STATES(7), .SAT_MODE(0), .CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .en(en), .step_up(step_up), .load(load),
    .load_val(load_val), .clr_cnt(clr_cnt), .state(st2), .at_top(top2),
    .at_bottom(bot2), .wrap_pulse(wp2), .wrap_cnt(wc2), .load_err(le2));

  function automatic obs_t dut_obs(int k);
    obs_t o;
    case (k)
      0: begin o.st = st0; o.top = top0; o.bot = bot0; o.wp = wp0; o.wc = wc0; o.le = le0; end
      1: begin o.st = st1; o.top = top1; o.bot = bot1; o.wp = wp1; o.wc = wc1; o.le = le1; end
      default: begin o.st = st2; o.top = top2; o.bot = bot2; o.wp = wp2; o.wc = {6'd0, wc2}; o.le = le2; end
    endcase
    return o;
  endfunction

  function automatic obs_t mdl_obs(int k);
    obs_t o;
    o.st  = 3'(m_st[k]);
    o.top = (m_st[k] == NS - 1);
    o.bot = (m_st[k] == 0);
    o.wp  = m_wp[k];
    o.wc  = 8'(m_wc[k]);
    o.le  = m_le[k];
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("st=%0d top=%0b bot=%0b wp=%0b cnt=%0d le=%0b",
                     o.st, o.top, o.bot, o.wp, o.wc, o.le);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_wc[k] = 0; m_wp[k] = 0; m_le[k] = 0;
    end
  endfunction

  function automatic void model_step(bit ld, int lv, bit e, bit up, bit clr);
    for (int k = 0; k < 3; k++) begin
      bit wrapped = 0;
      m_le[k] = 0;
      if (ld) begin
        if (lv < NS) m_st[k] = lv;
        else begin m_st[k] = NS - 1; m_le[k] = 1; end
      end else if (e) begin
        if (up) begin
          if (m_st[k] < NS - 1) m_st[k] = m_st[k] + 1;
          else if (m_sat[k] == 0) begin m_st[k] = 0; wrapped = 1; end
        end else if (m_st[k] > 0) begin
          m_st[k] = m_st[k] - 1;
        end
      end
      m_wp[k] = wrapped;
      if (clr) m_wc[k] = 0;
      else if (wrapped && m_wc[k] < m_cmax[k]) m_wc[k] = m_wc[k] + 1;
    end
  endfunction

  task automatic drive_cycle(input bit ld, input int lv, input bit e, input bit up, input bit clr);
    load = ld; load_val = 3'(lv); en = e; step_up = up; clr_cnt = clr;
    @(posedge clk);
    model_step(ld, lv, e, up, clr);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 0; step_up = 0; load = 0; load_val = 0; clr_cnt = 0;
    model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dut_obs(k) !== mdl_obs(k)) begin
        n_errors++;
        $display("FAIL reset inst%0d: got %s, expected %s", k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
      end
    end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (st0 !== 3'd0 || bot0 !== 1'b1 || top0 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: got st=%0d bot=%0b top=%0b, expected st=0 bot=1 top=0", st0, bot0, top0);
    end
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 10; i++) begin
      drive_cycle(0, 0, 1, 1, 0);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (dut_obs(k) !== mdl_obs(k)) begin
          n_errors++;
          $display("FAIL up_step%0d inst%0d: got %s, expected %s", i, k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
        end
      end
      if (i == 5) begin
        n_checks++;
        if (st0 !== 3'd6 || top0 !== 1'b1) begin
          n_errors++;
          $display("FAIL at_top: got st=%0d top=%0b, expected st=6 top=1", st0, top0);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (st0 !== 3'd0 || wp0 !== 1'b1 || wc0 !== 8'd1) begin
          n_errors++;
          $display("FAIL wrap: got st=%0d wp=%0b cnt=%0d, expected st=0 wp=1 cnt=1", st0, wp0, wc0);
        end
      end
      n_checks++;
      if (wp1 !== 1'b0) begin
        n_errors++;
        $display("FAIL sat_no_pulse step%0d: got wp=%0b, expected 0", i, wp1);
      end
    end
    n_checks++;
    if (st1 !== 3'd6 || wc1 !== 8'd0) begin
      n_errors++;
      $display("FAIL sat_hold: got st=%0d cnt=%0d, expected st=6 cnt=0", st1, wc1);
    end
  endtask

  task automatic test_down();
    int exp_st[5] = '{1, 0, 0, 0, 0};
    drive_cycle(1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, 1, 0, 0);
      n_checks++;
      if (st0 !== 3'(exp_st[i]) || bot0 !== (i >= 1)) begin
        n_errors++;
        $display("FAIL down_step%0d: got st=%0d bot=%0b, expected st=%0d bot=%0b",
                 i, st0, bot0, exp_st[i], (i >= 1));
      end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (dut_obs(k) !== mdl_obs(k)) begin
          n_errors++;
          $display("FAIL down_model%0d inst%0d: got %s, expected %s", i, k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
        end
      end
    end
  endtask

  task automatic test_load();
    drive_cycle(1, 3, 1, 1, 0);
    n_checks++;
    if (st0 !== 3'd3 || le0 !== 1'b0) begin
      n_errors++;
      $display("FAIL load_in_range: got st=%0d le=%0b, expected st=3 le=0", st0, le0);
    end
    drive_cycle(1, 7, 1, 0, 0);
    n_checks++;
    if (st0 !== 3'd6 || le0 !== 1'b1) begin
      n_errors++;
      $display("FAIL load_oor: got st=%0d le=%0b, expected st=6 le=1", st0, le0);
    end
    drive_cycle(0, 0, 0, 0, 0);
    n_checks++;
    if (st0 !== 3'd6 || le0 !== 1'b0) begin
      n_errors++;
      $display("FAIL load_err_width: got st=%0d le=%0b, expected st=6 le=0", st0, le0);
    end
    drive_cycle(1, 0, 1, 1, 0);
    n_checks++;
    if (st0 !== 3'd0 || wp0 !== 1'b0 || wc0 !== 8'(m_wc[0])) begin
      n_errors++;
      $display("FAIL load_zero_no_wrap: got st=%0d wp=%0b cnt=%0d, expected st=0 wp=0 cnt=%0d",
               st0, wp0, wc0, m_wc[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dut_obs(k) !== mdl_obs(k)) begin
        n_errors++;
        $display("FAIL load_model inst%0d: got %s, expected %s", k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
      end
    end
  endtask

  task automatic test_cnt_sat();
    int exp_wc[5] = '{1, 2, 3, 3, 3};
    drive_cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1, 6, 0, 0, 0);
      drive_cycle(0, 0, 1, 1, 0);
      n_checks++;
      if (wc2 !== 2'(exp_wc[i]) || wp2 !== 1'b1 || st2 !== 3'd0) begin
        n_errors++;
        $display("FAIL cnt_sat wrap%0d: got cnt=%0d wp=%0b st=%0d, expected cnt=%0d wp=1 st=0",
                 i, wc2, wp2, st2, exp_wc[i]);
      end
    end
    drive_cycle(1, 6, 0, 0, 0);
    drive_cycle(0, 0, 1, 1, 1);
    n_checks++;
    if (wc2 !== 2'd0 || wp2 !== 1'b1 || wc0 !== 8'd0 || wp0 !== 1'b1) begin
      n_errors++;
      $display("FAIL clr_on_wrap: got cnt2=%0d wp2=%0b cnt0=%0d wp0=%0b, expected cnt=0 wp=1 on both",
               wc2, wp2, wc0, wp0);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dut_obs(k) !== mdl_obs(k)) begin
        n_errors++;
        $display("FAIL cnt_model inst%0d: got %s, expected %s", k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
      end
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 5, 0, 0, 0);
    n_checks++;
    if (st0 !== 3'd5) begin
      n_errors++;
      $display("FAIL areset_setup: got st=%0d, expected 5", st0);
    end
    load = 0; en = 1; step_up = 1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dut_obs(k) !== mdl_obs(k)) begin
        n_errors++;
        $display("FAIL areset_now inst%0d: got %s, expected %s", k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
      end
    end
    #2 reset = 1'b0;
    drive_cycle(0, 0, 1, 1, 0);
    n_checks++;
    if (st0 !== 3'd1 || st1 !== 3'd1 || st2 !== 3'd1) begin
      n_errors++;
      $display("FAIL areset_first_step: got st=%0d/%0d/%0d, expected 1/1/1", st0, st1, st2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit ld  = ($urandom_range(0, 7) == 0);
      int lv  = $urandom_range(0, 7);
      bit e   = ($urandom_range(0, 3) != 0);
      bit up  = ($urandom_range(0, 9) < 7);
      bit clr = ($urandom_range(0, 15) == 0);
      drive_cycle(ld, lv, e, up, clr);
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (dut_obs(k) !== mdl_obs(k)) begin
          n_errors++;
          $display("FAIL random cyc%0d inst%0d: got %s, expected %s", i, k, fmt(dut_obs(k)), fmt(mdl_obs(k)));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_load();
    test_cnt_sat();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/step_fsm_gen.md
STEP_FSM_GEN -- requirements
Module: step_fsm_gen

Interface
REQ-001 The block SHALL have parameter NUM_STATES, default 7: number of states, legal range 2..256.
REQ-002 The block SHALL have parameter SAT_MODE, default 0: 0 = wrap top->0 on up-step, 1 = saturate at top.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of the wrap event counter, legal range 1..32.
REQ-004 The block SHALL derive SW = max(1, clog2(NUM_STATES)) as the state width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: step enable.
REQ-008 The block SHALL have port step_up, input, 1 bit: 1 = advance one state, 0 = retreat one state; sampled only when en=1.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous state load request.
REQ-010 The block SHALL have port load_val, input, SW bits: state value to load.
REQ-011 The block SHALL have port clr_cnt, input, 1 bit: synchronous clear of wrap_cnt.
REQ-012 The block SHALL have port state, output, SW bits: current state index.
REQ-013 The block SHALL have port at_top, output, 1 bit: combinational, state == NUM_STATES-1.
REQ-014 The block SHALL have port at_bottom, output, 1 bit: combinational, state == 0.
REQ-015 The block SHALL have port wrap_pulse, output, 1 bit: registered; high for exactly one cycle after a top->0 wrap.
REQ-016 The block SHALL have port wrap_cnt, output, CNT_W bits: registered saturating count of wraps.
REQ-017 The block SHALL have port load_err, output, 1 bit: registered; high for one cycle after an out-of-range load.

Function
REQ-018 Each cycle, the block SHALL apply exactly one action, in priority order: load, then step (en=1), then hold.
REQ-019 On load=1 with load_val < NUM_STATES, state SHALL become load_val next cycle, and en/step_up SHALL be ignored that cycle.
REQ-020 On load=1 with load_val >= NUM_STATES, state SHALL become NUM_STATES-1, load_err SHALL pulse for one cycle, and en/step_up SHALL be ignored that cycle.
REQ-021 On en=1, step_up=1 and state < NUM_STATES-1, state SHALL increment by 1.
REQ-022 On en=1, step_up=1 and state == NUM_STATES-1 with SAT_MODE=0, state SHALL become 0, and wrap_pulse SHALL be 1 in the following cycle.
REQ-023 On en=1, step_up=1 and state == NUM_STATES-1 with SAT_MODE=1, state SHALL hold, and wrap_pulse SHALL stay 0.
REQ-024 On en=1, step_up=0 and state > 0, state SHALL decrement by 1.
REQ-025 On en=1, step_up=0 and state == 0, state SHALL hold at 0 in both modes (no downward wrap).
REQ-026 On en=0 and load=0, state SHALL hold.
REQ-027 wrap_cnt SHALL increment by 1 on each cycle in which a wrap occurs, and SHALL saturate at 2^CNT_W-1.
REQ-028 When clr_cnt=1 coincides with a wrap, clr_cnt SHALL win: wrap_cnt becomes 0, while wrap_pulse still asserts.
REQ-029 A load SHALL never count as a wrap, including a load of 0 from the top state.
REQ-030 Latency from a qualifying input to state, wrap_pulse, wrap_cnt and load_err SHALL be one clock.
REQ-031 at_top and at_bottom SHALL be decoded from the state register only (Moore outputs), with no input-to-output combinational path.
REQ-032 Unreachable state encodings (>= NUM_STATES) SHALL recover to 0 on the next clock edge.

Reset
REQ-033 While reset=1, asynchronously: state=0, wrap_pulse=0, wrap_cnt=0, load_err=0; hence at_bottom=1, and at_top=0.
REQ-034 Reset asserted mid-step SHALL discard the pending step; the first clock edge after reset deassertion SHALL evaluate inputs normally.

Verification
REQ-035 Scenario (defaults): reset, then en=1, step_up=1 for 7 cycles -> state 0..6 then 0; at_top high at state 6; wrap_pulse for 1 cycle; wrap_cnt=1.
REQ-036 Scenario (SAT_MODE=1, NUM_STATES=7): 10 up-steps -> state stays 6, wrap_pulse never high, wrap_cnt=0.
REQ-037 Scenario: from state 2, 5 down-steps -> 1, 0, 0, 0, 0; at_bottom high from the second step on.
REQ-038 Scenario: load=1, load_val=3 with en=1, step_up=1 -> state=3 (step ignored); load_val=7 (NUM_STATES=7) -> state=6, load_err 1-cycle pulse.
REQ-039 Scenario (CNT_W=2): 5 wraps -> wrap_cnt 1, 2, 3, 3, 3; clr_cnt on a wrap cycle -> wrap_cnt=0, wrap_pulse=1.
REQ-040 Scenario: reset asserted asynchronously between edges at state 5 -> state=0 immediately; deassert, 1 up-step -> state=1.
